// File: rtl/ps2_num_entry_if.sv
// Bundles the PS/2 keyboard lines and the number-entry results of ps2_num_entry.
// The keyboard/consumer side uses the master modport; the entry block uses the slave modport.
interface ps2_num_entry_if #(
    parameter int NUM_DIGITS = 3
);
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic                    PS2_CLK;
    logic                    PS2_DATA;
    logic [4*NUM_DIGITS-1:0] oEntry;
    logic [CW-1:0]           oCount;
    logic [4*NUM_DIGITS-1:0] oNum;
    logic                    oNumRdy;
    logic                    oErr;

    modport master (
        output PS2_CLK, PS2_DATA,
        input  oEntry, oCount, oNum, oNumRdy, oErr
    );

    modport slave (
        input  PS2_CLK, PS2_DATA,
        output oEntry, oCount, oNum, oNumRdy, oErr
    );
endinterface

// File: rtl/ps2_num_entry.sv
// PS/2 keyboard receiver feeding a fixed-length decimal entry buffer.
// Digit key releases fill the buffer; Backspace, Escape and Enter edit or commit it.
module ps2_num_entry #(
    parameter int NUM_DIGITS  = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 CLK,
    input  logic                 reset,
    ps2_num_entry_if.slave       bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]              r_clk_sync;
    logic [1:0]              r_data_sync;
    logic                    r_clk_prev;
    state_t                  r_state;
    state_t                  w_state_next;
    logic [2:0]              r_bit_cnt;
    logic [7:0]              r_shift;
    logic                    r_parity;
    logic [TW-1:0]           r_idle_cnt;
    logic [7:0]              r_byte;
    logic                    r_strobe;
    logic                    r_frame_err;
    logic                    r_entry_err;
    logic                    r_ext;
    logic                    r_brk;
    logic [4*NUM_DIGITS-1:0] r_entry;
    logic [CW-1:0]           r_count;
    logic [4*NUM_DIGITS-1:0] r_num;
    logic                    r_num_rdy;
    logic                    w_edge;
    logic                    w_data;
    logic                    w_frame_ok;
    logic                    w_frame_bad;
    logic                    w_timeout;
    logic                    w_digit_valid;
    logic [3:0]              w_digit_val;

    // Synchronisers idle high, matching an idle PS/2 bus, so reset never fakes an edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value of its neighbour.
            r_clk_sync  <= {r_clk_sync[0], bus.PS2_CLK};
            r_data_sync <= {r_data_sync[0], bus.PS2_DATA};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_edge = r_clk_prev & ~r_clk_sync[1];
    assign w_data = r_data_sync[1];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_frame_ok   = 1'b0;
        w_frame_bad  = 1'b0;
        w_timeout    = 1'b0;
        if (w_edge) begin
            case (r_state)
                S_IDLE:   if (!w_data) w_state_next = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
                S_PARITY: w_state_next = S_STOP;
                S_STOP: begin
                    w_state_next = S_IDLE;
                    if (((^r_shift) ^ r_parity) && w_data) w_frame_ok  = 1'b1;
                    else                                   w_frame_bad = 1'b1;
                end
                default:  w_state_next = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
            w_state_next = S_IDLE;
            w_timeout    = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_idle_cnt  <= '0;
            r_byte      <= '0;
            r_strobe    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_strobe    <= w_frame_ok;
            r_frame_err <= w_frame_bad | w_timeout;
            if (w_frame_ok) r_byte <= r_shift;
            if (w_edge) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_parity <= w_data;
                    default:  ;
                endcase
            end
            if (w_edge || w_timeout || r_state == S_IDLE) r_idle_cnt <= '0;
            else                                          r_idle_cnt <= r_idle_cnt + TW'(1);
        end
    end

    always_comb begin
        w_digit_valid = 1'b1;
        w_digit_val   = 4'd0;
        case (r_byte)
            8'h45: w_digit_val = 4'd0;
            8'h16: w_digit_val = 4'd1;
            8'h1E: w_digit_val = 4'd2;
            8'h26: w_digit_val = 4'd3;
            8'h25: w_digit_val = 4'd4;
            8'h2E: w_digit_val = 4'd5;
            8'h36: w_digit_val = 4'd6;
            8'h3D: w_digit_val = 4'd7;
            8'h3E: w_digit_val = 4'd8;
            8'h46: w_digit_val = 4'd9;
            default: w_digit_valid = 1'b0;
        endcase
    end

    // Only a plain key release acts; E0 and F0 prefixes just arm the flags.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_entry     <= '0;
            r_count     <= '0;
            r_num       <= '0;
            r_num_rdy   <= 1'b0;
            r_entry_err <= 1'b0;
        end else begin
            r_num_rdy   <= 1'b0;
            r_entry_err <= 1'b0;
            if (r_strobe) begin
                if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (r_brk && !r_ext) begin
                        if (w_digit_valid) begin
                            if (r_count < CW'(NUM_DIGITS)) begin
                                for (int k = 0; k < NUM_DIGITS; k++)
                                    if (k == int'(r_count)) r_entry[4*k +: 4] <= w_digit_val;
                                r_count <= r_count + CW'(1);
                            end else begin
                                r_entry_err <= 1'b1;
                            end
                        end else begin
                            case (r_byte)
                                8'h66: if (r_count != '0) begin
                                    for (int k = 0; k < NUM_DIGITS; k++)
                                        if (k == int'(r_count) - 1) r_entry[4*k +: 4] <= 4'd0;
                                    r_count <= r_count - CW'(1);
                                end
                                8'h76: begin
                                    r_entry <= '0;
                                    r_count <= '0;
                                end
                                8'h5A: if (r_count == CW'(NUM_DIGITS)) begin
                                    r_num     <= r_entry;
                                    r_num_rdy <= 1'b1;
                                    r_entry   <= '0;
                                    r_count   <= '0;
                                end else begin
                                    r_entry_err <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
        end
    end

    assign bus.oEntry  = r_entry;
    assign bus.oCount  = r_count;
    assign bus.oNum    = r_num;
    assign bus.oNumRdy = r_num_rdy;
    assign bus.oErr    = r_frame_err | r_entry_err;
endmodule

// File: tb/tb_ps2_num_entry.sv
// Directed bench for ps2_num_entry: drives PS/2 frames bit by bit and checks the
// entry buffer, committed number and pulse counts against hand-computed values.
module tb_ps2_num_entry;
    localparam int ND = 3;
    localparam int TO = 300;

    logic CLK = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   rdy_cnt = 0;
    int   err_cnt = 0;
    int   consec = 0;
    logic prev_rdy = 1'b0;
    logic prev_err = 1'b0;

    ps2_num_entry_if #(.NUM_DIGITS(ND)) bus ();

    ps2_num_entry #(.NUM_DIGITS(ND), .TIMEOUT_CYC(TO)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Pulse counters and back-to-back detector, sampled away from the active edge.
    always @(negedge CLK) begin
        if (bus.oNumRdy) rdy_cnt++;
        if (bus.oErr) err_cnt++;
        if ((bus.oNumRdy && prev_rdy) || (bus.oErr && prev_err)) consec++;
        prev_rdy = bus.oNumRdy;
        prev_err = bus.oErr;
    end

    task automatic send_bit(input logic b);
        bus.PS2_DATA = b;
        repeat (8) @(posedge CLK);
        bus.PS2_CLK = 1'b0;
        repeat (8) @(posedge CLK);
        bus.PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        bus.PS2_DATA = 1'b1;
        repeat (20) @(posedge CLK);
    endtask

    task automatic release_key(input logic [7:0] code);
        send_frame(8'hF0, 1'b0);
        send_frame(code, 1'b0);
    endtask

    task automatic press_release(input logic [7:0] code);
        send_frame(code, 1'b0);
        release_key(code);
    endtask

    task automatic test_reset();
        bus.PS2_CLK = 1'b1;
        bus.PS2_DATA = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if ({bus.oEntry, bus.oCount, bus.oNum, bus.oNumRdy, bus.oErr} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got entry=%h count=%0d num=%h rdy=%b err=%b want all 0",
                     bus.oEntry, bus.oCount, bus.oNum, bus.oNumRdy, bus.oErr);
        end
        reset = 1'b0;
        repeat (5) @(posedge CLK);
    endtask

    task automatic test_commit();
        int r0;
        int e0;
        release_key(8'h16);
        release_key(8'h1E);
        release_key(8'h26);
        @(negedge CLK);
        vectors++;
        if (bus.oEntry !== 12'h321 || bus.oCount !== 2'd3) begin
            miscompares++;
            $display("FAIL commit_fill: got entry=%h count=%0d want 321/3", bus.oEntry, bus.oCount);
        end
        r0 = rdy_cnt;
        e0 = err_cnt;
        release_key(8'h5A);
        @(negedge CLK);
        vectors++;
        if (bus.oNum !== 12'h321) begin
            miscompares++;
            $display("FAIL commit_num: got %h want 321", bus.oNum);
        end
        vectors++;
        if (rdy_cnt - r0 !== 1 || err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL commit_pulses: got rdy=%0d err=%0d want 1/0", rdy_cnt - r0, err_cnt - e0);
        end
        vectors++;
        if (bus.oEntry !== 12'h000 || bus.oCount !== 2'd0) begin
            miscompares++;
            $display("FAIL commit_clear: got entry=%h count=%0d want 000/0", bus.oEntry, bus.oCount);
        end
    endtask

    task automatic test_backspace();
        int r0;
        int e0;
        press_release(8'h3D);
        press_release(8'h3E);
        press_release(8'h66);
        press_release(8'h46);
        @(negedge CLK);
        vectors++;
        if (bus.oEntry !== 12'h097 || bus.oCount !== 2'd2) begin
            miscompares++;
            $display("FAIL bksp_edit: got entry=%h count=%0d want 097/2", bus.oEntry, bus.oCount);
        end
        r0 = rdy_cnt;
        e0 = err_cnt;
        release_key(8'h5A);
        @(negedge CLK);
        vectors++;
        if (err_cnt - e0 !== 1 || rdy_cnt - r0 !== 0) begin
            miscompares++;
            $display("FAIL short_enter_pulses: got err=%0d rdy=%0d want 1/0", err_cnt - e0, rdy_cnt - r0);
        end
        vectors++;
        if (bus.oEntry !== 12'h097 || bus.oCount !== 2'd2 || bus.oNum !== 12'h321) begin
            miscompares++;
            $display("FAIL short_enter_hold: got entry=%h count=%0d num=%h want 097/2/321",
                     bus.oEntry, bus.oCount, bus.oNum);
        end
    endtask

    task automatic test_escape();
        int e0;
        e0 = err_cnt;
        release_key(8'h76);
        @(negedge CLK);
        vectors++;
        if (bus.oEntry !== 12'h000 || bus.oCount !== 2'd0) begin
            miscompares++;
            $display("FAIL escape_clear: got entry=%h count=%0d want 000/0", bus.oEntry, bus.oCount);
        end
        release_key(8'h66);
        @(negedge CLK);
        vectors++;
        if (bus.oEntry !== 12'h000 || bus.oCount !== 2'd0 || err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL bksp_empty: got entry=%h count=%0d err=%0d want 000/0/0",
                     bus.oEntry, bus.oCount, err_cnt - e0);
        end
    endtask

    task automatic test_bad_parity();
        int e0;
        release_key(8'h16);
        e0 = err_cnt;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h16, 1'b1);
        @(negedge CLK);
        vectors++;
        if (err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL parity_err: got %0d pulses want 1", err_cnt - e0);
        end
        vectors++;
        if (bus.oEntry !== 12'h001 || bus.oCount !== 2'd1) begin
            miscompares++;
            $display("FAIL parity_discard: got entry=%h count=%0d want 001/1", bus.oEntry, bus.oCount);
        end
        // The break flag armed before the bad frame is still set.
        send_frame(8'h16, 1'b0);
        @(negedge CLK);
        vectors++;
        if (bus.oEntry !== 12'h011 || bus.oCount !== 2'd2) begin
            miscompares++;
            $display("FAIL parity_recover: got entry=%h count=%0d want 011/2", bus.oEntry, bus.oCount);
        end
        release_key(8'h76);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.PS2_DATA = 1'b1;
        repeat (TO / 2) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL timeout_early: got %0d pulses want 0", err_cnt - e0);
        end
        repeat (TO) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0);
        end
        release_key(8'h45);
        @(negedge CLK);
        vectors++;
        if (bus.oEntry !== 12'h000 || bus.oCount !== 2'd1 || err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL timeout_recover: got entry=%h count=%0d err=%0d want 000/1/1",
                     bus.oEntry, bus.oCount, err_cnt - e0);
        end
        release_key(8'h76);
    endtask

    task automatic test_ignored();
        int r0;
        int e0;
        release_key(8'h16);
        release_key(8'h1E);
        release_key(8'h26);
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b0);
        release_key(8'h1C);
        @(negedge CLK);
        vectors++;
        if (bus.oEntry !== 12'h321 || bus.oCount !== 2'd3) begin
            miscompares++;
            $display("FAIL ignored_hold: got entry=%h count=%0d want 321/3", bus.oEntry, bus.oCount);
        end
        vectors++;
        if (err_cnt - e0 !== 0 || rdy_cnt - r0 !== 0) begin
            miscompares++;
            $display("FAIL ignored_pulses: got err=%0d rdy=%0d want 0/0", err_cnt - e0, rdy_cnt - r0);
        end
        release_key(8'h16);
        @(negedge CLK);
        vectors++;
        if (err_cnt - e0 !== 1 || bus.oEntry !== 12'h321 || bus.oCount !== 2'd3) begin
            miscompares++;
            $display("FAIL overflow: got err=%0d entry=%h count=%0d want 1/321/3",
                     err_cnt - e0, bus.oEntry, bus.oCount);
        end
        release_key(8'h76);
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = rdy_cnt;
        release_key(8'h25);
        release_key(8'h2E);
        release_key(8'h36);
        release_key(8'h5A);
        @(negedge CLK);
        vectors++;
        if (bus.oNum !== 12'h654 || rdy_cnt - r0 !== 1) begin
            miscompares++;
            $display("FAIL b2b_first: got num=%h rdy=%0d want 654/1", bus.oNum, rdy_cnt - r0);
        end
        release_key(8'h45);
        release_key(8'h45);
        release_key(8'h46);
        release_key(8'h5A);
        @(negedge CLK);
        vectors++;
        if (bus.oNum !== 12'h900 || rdy_cnt - r0 !== 2 || bus.oCount !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b_second: got num=%h rdy=%0d count=%0d want 900/2/0",
                     bus.oNum, rdy_cnt - r0, bus.oCount);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'h1E;
        release_key(8'h16);
        send_frame(8'hF0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(b[i]);
        bus.PS2_DATA = b[5];
        repeat (4) @(posedge CLK);
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if ({bus.oEntry, bus.oCount, bus.oNum, bus.oNumRdy, bus.oErr} !== '0) begin
            miscompares++;
            $display("FAIL midframe_reset: got entry=%h count=%0d num=%h rdy=%b err=%b want all 0",
                     bus.oEntry, bus.oCount, bus.oNum, bus.oNumRdy, bus.oErr);
        end
        reset = 1'b0;
        bus.PS2_DATA = 1'b1;
        repeat (20) @(posedge CLK);
        release_key(8'h16);
        @(negedge CLK);
        vectors++;
        if (bus.oEntry !== 12'h001 || bus.oCount !== 2'd1) begin
            miscompares++;
            $display("FAIL midframe_recover: got entry=%h count=%0d want 001/1", bus.oEntry, bus.oCount);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_backspace();
        test_escape();
        test_bad_parity();
        test_timeout();
        test_ignored();
        test_back_to_back();
        test_reset_midframe();
        vectors++;
        if (consec !== 0) begin
            miscompares++;
            $display("FAIL pulse_width: got %0d back-to-back pulse cycles want 0", consec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
